// File: rtl/rc_pulse_decoder.sv
// rc_pulse_decoder: measures the high time of four RC receiver PWM lines, quantises each
// to an 8-bit offset, and raises per-channel update strobes plus a throttle-driven link flag.
module rc_pulse_decoder #(
    parameter int TICK_DIV      = 1250,
    parameter int MIN_TICKS     = 40,
    parameter int FULL_POINT    = 40,
    parameter int GLITCH_TICKS  = 30,
    parameter int MAX_TICKS     = 100,
    parameter int TIMEOUT_TICKS = 1000,
    parameter int HALF_POINT    = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] rc_in,
    output logic [7:0] throttle_offset,
    output logic [7:0] pitch_offset,
    output logic [7:0] roll_offset,
    output logic [7:0] yaw_offset,
    output logic [3:0] ch_update,
    output logic       link_ok
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [7:0]       GLITCH8   = 8'(GLITCH_TICKS);
    localparam logic [7:0]       MAX8      = 8'(MAX_TICKS);
    localparam logic [8:0]       MIN9      = 9'(MIN_TICKS);
    localparam logic [8:0]       FULL9     = 9'(FULL_POINT);
    localparam logic [7:0]       FULL8     = 8'(FULL_POINT);
    localparam logic [7:0]       HALF8     = 8'(HALF_POINT);
    localparam logic [15:0]      TMO_LAST  = 16'(TIMEOUT_TICKS - 1);

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        ARMED    = 2'd1,
        MEASURE  = 2'd2
    } state_t;

    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [3:0]       r_prev;
    logic [3:0]       w_rise;
    logic [3:0]       w_fall;
    logic [DIV_W-1:0] r_div;
    logic             w_tick;
    state_t           r_state     [4];
    state_t           w_state_nxt [4];
    logic [7:0]       r_cnt       [4];
    logic [7:0]       r_off       [4];
    logic [3:0]       w_accept;
    logic [15:0]      r_tmo;
    logic             w_expire;
    logic [3:0]       r_upd;
    logic             r_link;

    // Width in ticks -> offset; the range check comes first so the subtraction never wraps.
    function automatic logic [7:0] quantise(input logic [7:0] cnt);
        logic [8:0] cnt9;
        logic [8:0] diff;
        cnt9 = {1'b0, cnt};
        if (cnt9 < MIN9) begin
            return 8'd0;
        end
        diff = cnt9 - MIN9;
        return (diff > FULL9) ? FULL8 : diff[7:0];
    endfunction

    // Synchronisers reset high so a line held high through reset never looks like a rising edge.
    // NOTE: non-blocking assignments make every flop sample the pre-edge value of its source,
    // which is what turns three statements into a three-stage shift chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_prev  <= '1;
        end else begin
            r_sync1 <= rc_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_rise = r_sync2 & ~r_prev;
    assign w_fall = ~r_sync2 & r_prev;

    assign w_tick = (r_div == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // NOTE: every output of this block gets a default before the case, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            w_state_nxt[n] = r_state[n];
            w_accept[n]    = 1'b0;
            unique case (r_state[n])
                WAIT_LOW: begin
                    if (!r_sync2[n]) begin
                        w_state_nxt[n] = ARMED;
                    end
                end
                ARMED: begin
                    if (w_rise[n]) begin
                        w_state_nxt[n] = MEASURE;
                    end
                end
                MEASURE: begin
                    if (w_fall[n]) begin
                        w_state_nxt[n] = ARMED;
                        w_accept[n]    = (r_cnt[n] >= GLITCH8) && (r_cnt[n] <= MAX8);
                    end
                end
                default: w_state_nxt[n] = WAIT_LOW;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 4; n++) begin
                r_state[n] <= WAIT_LOW;
                r_cnt[n]   <= '0;
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                r_state[n] <= w_state_nxt[n];
                if (r_state[n] == ARMED && w_rise[n]) begin
                    r_cnt[n] <= '0;
                end else if (r_state[n] == MEASURE && w_tick && r_cnt[n] != 8'hFF) begin
                    r_cnt[n] <= r_cnt[n] + 8'd1;
                end
            end
        end
    end

    // A throttle accept in the expiry cycle clears the counter and suppresses the expiry.
    assign w_expire = w_tick && (r_tmo == TMO_LAST) && !w_accept[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo <= '0;
        end else if (w_accept[0]) begin
            r_tmo <= '0;
        end else if (w_tick && r_tmo != 16'hFFFF) begin
            r_tmo <= r_tmo + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 4; n++) begin
                r_off[n] <= (n == 0) ? 8'd0 : HALF8;
            end
            r_upd  <= '0;
            r_link <= 1'b0;
        end else begin
            r_upd <= w_accept;
            if (w_accept[0]) begin
                r_link <= 1'b1;
            end else if (w_expire) begin
                r_link <= 1'b0;
            end
            for (int n = 0; n < 4; n++) begin
                if (w_accept[n]) begin
                    r_off[n] <= quantise(r_cnt[n]);
                end else if (w_expire) begin
                    r_off[n] <= (n == 0) ? 8'd0 : HALF8;
                end
            end
        end
    end

    assign throttle_offset = r_off[0];
    assign pitch_offset    = r_off[1];
    assign roll_offset     = r_off[2];
    assign yaw_offset      = r_off[3];
    assign ch_update       = r_upd;
    assign link_ok         = r_link;

endmodule
